q_ctrl_multi: RTL and testbench
===============================

Name: q_ctrl_multi

Overview:
- Multi-channel, time-multiplexed successor to the single-channel Q control loop.
- Runs one bisection search per channel. A single shared Q measurement path is driven through a start/ready handshake, and channels are served round-robin.
- Mode select: per-channel hold after lock, or incremental tracking with automatic re-search.
- Sits between the shared q_measurement instance and the per-channel i_ref drivers.

Parameters:
- BUS_WIDTH, 10, width of Q and i_ref words.
- NUM_CH, 4, number of channels (>=2).
- CH_IDX_WIDTH, 2, width of channel index; must satisfy 2**CH_IDX_WIDTH >= NUM_CH.
- TOL, 1, lock tolerance on |q_desired - q_measured|.
- STEP, 4, i_ref increment per tracking update.
- RELOCK_THR, 50, tracking error above which the channel restarts bisection.
- MAX_ITER, 12, bisection measurements before forced lock.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  run/halt the scheduler.
- mode  in  1  0 = hold after lock; 1 = track after lock.
- ready  in  1  one-cycle pulse; q_measured valid for meas_ch.
- q_measured  in  BUS_WIDTH  measured Q.
- q_desired  in  NUM_CH*BUS_WIDTH  packed targets; channel k at [k*BUS_WIDTH +: BUS_WIDTH].
- i_ref_max  in  NUM_CH*BUS_WIDTH  packed per-channel upper bounds.
- meas_start  out  1  one-cycle measurement request.
- meas_ch  out  CH_IDX_WIDTH  channel being measured.
- i_ref  out  NUM_CH*BUS_WIDTH  packed registered i_ref per channel.
- locked  out  NUM_CH  per-channel lock flag.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - Outputs: i_ref all 0, locked 0, meas_start 0, meas_ch 0, busy 0.
  - Internal: per-channel lo = 0, hi = 0, iter = 0, need_init = all 1; state IDLE, channel pointer 0.
  - rst in any state (including mid-WAIT) aborts immediately; a later ready is ignored.
- FSM states: IDLE, LOAD, START, WAIT, UPDATE, NEXT.
- IDLE: enable=1 -> LOAD.
- LOAD (1 cycle):
  - If need_init[ch]: lo=0, hi=i_ref_max[ch], i_ref[ch]=i_ref_max[ch]>>1, iter=0, locked[ch]=0, need_init[ch]=0.
  - Then -> START.
- START (1 cycle): meas_start=1, meas_ch=ch -> WAIT.
- WAIT:
  - ready=1 -> UPDATE, with q_measured captured.
  - enable=0 -> IDLE: no update, pointer kept, outputs held.
  - ready outside WAIT is ignored.
- UPDATE (1 cycle):
  - err = q_desired[ch] - q_measured as signed BUS_WIDTH+1.
  - Bisection (locked[ch]=0):
    - |err|<=TOL -> locked=1, i_ref unchanged.
    - Else err>0 -> lo=i_ref; err<0 -> hi=i_ref. Then i_ref=(lo+hi)>>1, computed with a BUS_WIDTH+1-bit sum (no overflow). iter++.
    - If the new hi-lo<=1, or iter reaches MAX_ITER -> locked=1.
  - Locked, mode=0: no change.
  - Locked, mode=1:
    - |err|>RELOCK_THR -> need_init=1, locked=0; restart happens at the next LOAD of this channel.
    - Else |err|>TOL -> i_ref += STEP (err>0) or -= STEP (err<0), saturating to [0, i_ref_max[ch]].
    - Else no change.
  - Any update clamps i_ref to i_ref_max[ch] if the bound has dropped.
  - New i_ref is visible the cycle after UPDATE. Then -> NEXT.
- NEXT:
  - ch = (ch==NUM_CH-1) ? 0 : ch+1.
  - enable=1 -> LOAD, else -> IDLE.
- Timing and boundaries:
  - Per-channel overhead is 5 cycles plus measurement latency.
  - Packed buses are read live; q_desired changes take effect at the channel's next UPDATE.
  - i_ref_max[ch]=0 -> i_ref=0; locks on the first UPDATE (hi-lo<=1).
  - Locked channels in mode 0 are still visited and measured; there is no skip.

Test Plan:
- Reset mid-WAIT: pulse rst, then ready -> all outputs at reset values, state IDLE, no i_ref change.
- Single-target bisection (BUS_WIDTH=10, TOL=1):
  - Setup: ch0 i_ref_max=1023, q_desired=300, model q=i_ref.
  - Required: ch0 i_ref sequence 511,255,383,319,287,303,295,299.
  - Required: locked[0]=1 after the 8th measurement.
- Round-robin: NUM_CH=4, enable held -> meas_ch sequence 0,1,2,3,0; exactly one meas_start per channel visit; ch3 wraps to 0.
- Tracking (mode=1): after ch0 locks at 299, change model to q=i_ref-10.
  - Required: i_ref steps +4 per ch0 visit to 307 (q=297 -> err=3 -> 311; err=-1 -> hold).
  - Then force q_desired=900 -> err>50 -> locked[0]=0 and restart from i_ref=511.
- Boundaries:
  - i_ref_max=0 -> i_ref=0, locks after the first measurement.
  - Tracking at i_ref=1021, err=+20, max=1023 -> i_ref saturates at 1023.
- Enable drop in WAIT: deassert enable before ready -> IDLE, i_ref/locked unchanged. Re-enable -> resumes at the same channel with LOAD.

Source files
------------

// File: rtl/q_ctrl_multi_if.sv
// Bundle between q_ctrl_multi, the shared Q measurement path and the per-channel
// i_ref drivers. The controller is the master: it issues measurement requests.
interface q_ctrl_multi_if #(
    parameter int BUS_WIDTH    = 10,
    parameter int NUM_CH       = 4,
    parameter int CH_IDX_WIDTH = 2
);
    logic                        enable;
    logic                        mode;
    logic                        ready;
    logic [BUS_WIDTH-1:0]        q_measured;
    logic [NUM_CH*BUS_WIDTH-1:0] q_desired;
    logic [NUM_CH*BUS_WIDTH-1:0] i_ref_max;
    logic                        meas_start;
    logic [CH_IDX_WIDTH-1:0]     meas_ch;
    logic [NUM_CH*BUS_WIDTH-1:0] i_ref;
    logic [NUM_CH-1:0]           locked;
    logic                        busy;

    modport master (
        input  enable, mode, ready, q_measured, q_desired, i_ref_max,
        output meas_start, meas_ch, i_ref, locked, busy
    );

    modport slave (
        output enable, mode, ready, q_measured, q_desired, i_ref_max,
        input  meas_start, meas_ch, i_ref, locked, busy
    );
endinterface

// File: rtl/q_ctrl_multi.sv
// Time-multiplexed Q control loop: one bisection search (plus optional tracking)
// per channel, sharing a single Q measurement path served round-robin.
module q_ctrl_multi #(
    parameter int BUS_WIDTH    = 10,
    parameter int NUM_CH       = 4,
    parameter int CH_IDX_WIDTH = 2,
    parameter int TOL          = 1,
    parameter int STEP         = 4,
    parameter int RELOCK_THR   = 50,
    parameter int MAX_ITER     = 12
) (
    input  logic           clk,
    input  logic           rst,
    q_ctrl_multi_if.master bus
);
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam logic [BUS_WIDTH:0]      TOL_W    = (BUS_WIDTH+1)'(TOL);
    localparam logic [BUS_WIDTH:0]      STEP_W   = (BUS_WIDTH+1)'(STEP);
    localparam logic [BUS_WIDTH:0]      RELOCK_W = (BUS_WIDTH+1)'(RELOCK_THR);
    localparam logic [BUS_WIDTH:0]      ONE_W    = (BUS_WIDTH+1)'(1);
    localparam logic [ITER_W-1:0]       ITER_MAX = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0]       ITER_ONE = ITER_W'(1);
    localparam logic [CH_IDX_WIDTH-1:0] CH_LAST  = CH_IDX_WIDTH'(NUM_CH - 1);
    localparam logic [CH_IDX_WIDTH-1:0] CH_ONE   = CH_IDX_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_NEXT   = 3'd5
    } state_t;

    function automatic logic [BUS_WIDTH:0] abs_err(input logic signed [BUS_WIDTH:0] e);
        logic [BUS_WIDTH:0] mag;
        if (e[BUS_WIDTH]) begin
            mag = $unsigned(-e);
        end else begin
            mag = $unsigned(e);
        end
        return mag;
    endfunction

    // One tracking step, saturating to [0, bound].
    function automatic logic [BUS_WIDTH-1:0] step_ref(input logic [BUS_WIDTH-1:0] cur,
                                                      input logic up,
                                                      input logic [BUS_WIDTH-1:0] bound);
        logic [BUS_WIDTH:0]   sum;
        logic [BUS_WIDTH-1:0] res;
        sum = {1'b0, cur} + STEP_W;
        if (up) begin
            res = (sum > {1'b0, bound}) ? bound : sum[BUS_WIDTH-1:0];
        end else begin
            res = ({1'b0, cur} < STEP_W) ? {BUS_WIDTH{1'b0}} : cur - STEP_W[BUS_WIDTH-1:0];
        end
        return res;
    endfunction

    state_t                  state_r;
    logic [CH_IDX_WIDTH-1:0] ch_r;
    logic                    meas_start_r;
    logic [CH_IDX_WIDTH-1:0] meas_ch_r;
    logic                    busy_r;
    logic [BUS_WIDTH-1:0]    q_cap_r;
    logic [BUS_WIDTH-1:0]    i_ref_r [NUM_CH];
    logic [BUS_WIDTH-1:0]    lo_r    [NUM_CH];
    logic [BUS_WIDTH-1:0]    hi_r    [NUM_CH];
    logic [ITER_W-1:0]       iter_r  [NUM_CH];
    logic [NUM_CH-1:0]       locked_r;
    logic [NUM_CH-1:0]       need_init_r;

    logic [BUS_WIDTH-1:0]    q_des_a [NUM_CH];
    logic [BUS_WIDTH-1:0]    max_a   [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign q_des_a[k] = bus.q_desired[k*BUS_WIDTH +: BUS_WIDTH];
        assign max_a[k]   = bus.i_ref_max[k*BUS_WIDTH +: BUS_WIDTH];
        assign bus.i_ref[k*BUS_WIDTH +: BUS_WIDTH] = i_ref_r[k];
    end

    assign bus.meas_start = meas_start_r;
    assign bus.meas_ch    = meas_ch_r;
    assign bus.locked     = locked_r;
    assign bus.busy       = busy_r;

    logic signed [BUS_WIDTH:0] err_s;
    logic [BUS_WIDTH:0]        mag_s;
    logic [BUS_WIDTH:0]        sum_s;
    logic [BUS_WIDTH-1:0]      bound_s;
    logic [BUS_WIDTH-1:0]      nxt_ref_s;
    logic [BUS_WIDTH-1:0]      clamped_ref_s;
    logic [BUS_WIDTH-1:0]      nxt_lo_s;
    logic [BUS_WIDTH-1:0]      nxt_hi_s;
    logic [ITER_W-1:0]         nxt_iter_s;
    logic                      nxt_locked_s;
    logic                      nxt_init_s;

    // Next per-channel search state for the channel currently in UPDATE.
    always_comb begin
        bound_s      = max_a[ch_r];
        err_s        = $signed({1'b0, q_des_a[ch_r]}) - $signed({1'b0, q_cap_r});
        mag_s        = abs_err(err_s);
        sum_s        = {(BUS_WIDTH+1){1'b0}};
        nxt_ref_s    = i_ref_r[ch_r];
        nxt_lo_s     = lo_r[ch_r];
        nxt_hi_s     = hi_r[ch_r];
        nxt_iter_s   = iter_r[ch_r];
        nxt_locked_s = locked_r[ch_r];
        nxt_init_s   = 1'b0;
        if (!locked_r[ch_r]) begin
            if (mag_s <= TOL_W) begin
                nxt_locked_s = 1'b1;
            end else begin
                if (err_s[BUS_WIDTH]) begin
                    nxt_hi_s = i_ref_r[ch_r];
                end else begin
                    nxt_lo_s = i_ref_r[ch_r];
                end
                // Sum is one bit wider so the midpoint never overflows.
                sum_s      = {1'b0, nxt_lo_s} + {1'b0, nxt_hi_s};
                nxt_ref_s  = BUS_WIDTH'(sum_s >> 1);
                nxt_iter_s = iter_r[ch_r] + ITER_ONE;
                if (({1'b0, nxt_hi_s} <= ({1'b0, nxt_lo_s} + ONE_W)) || (nxt_iter_s >= ITER_MAX)) begin
                    nxt_locked_s = 1'b1;
                end else begin
                    nxt_locked_s = 1'b0;
                end
            end
        end else if (bus.mode) begin
            if (mag_s > RELOCK_W) begin
                nxt_init_s   = 1'b1;
                nxt_locked_s = 1'b0;
            end else if (mag_s > TOL_W) begin
                nxt_ref_s = step_ref(i_ref_r[ch_r], ~err_s[BUS_WIDTH], bound_s);
            end else begin
                nxt_ref_s = i_ref_r[ch_r];
            end
        end else begin
            nxt_ref_s = i_ref_r[ch_r];
        end
        // A bound lowered since the last visit still takes effect here.
        if (nxt_ref_s > bound_s) begin
            clamped_ref_s = bound_s;
        end else begin
            clamped_ref_s = nxt_ref_s;
        end
    end

    // Scheduler FSM with registered outputs and per-channel state updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ch_r         <= {CH_IDX_WIDTH{1'b0}};
            meas_start_r <= 1'b0;
            meas_ch_r    <= {CH_IDX_WIDTH{1'b0}};
            busy_r       <= 1'b0;
            q_cap_r      <= {BUS_WIDTH{1'b0}};
            locked_r     <= {NUM_CH{1'b0}};
            need_init_r  <= {NUM_CH{1'b1}};
            for (int k = 0; k < NUM_CH; k++) begin
                i_ref_r[k] <= {BUS_WIDTH{1'b0}};
                lo_r[k]    <= {BUS_WIDTH{1'b0}};
                hi_r[k]    <= {BUS_WIDTH{1'b0}};
                iter_r[k]  <= {ITER_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (need_init_r[ch_r]) begin
                        lo_r[ch_r]        <= {BUS_WIDTH{1'b0}};
                        hi_r[ch_r]        <= max_a[ch_r];
                        i_ref_r[ch_r]     <= max_a[ch_r] >> 1;
                        iter_r[ch_r]      <= {ITER_W{1'b0}};
                        locked_r[ch_r]    <= 1'b0;
                        need_init_r[ch_r] <= 1'b0;
                    end
                    meas_start_r <= 1'b1;
                    meas_ch_r    <= ch_r;
                    state_r      <= ST_START;
                end
                ST_START: begin
                    meas_start_r <= 1'b0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.ready) begin
                        q_cap_r <= bus.q_measured;
                        state_r <= ST_UPDATE;
                    end else if (!bus.enable) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    i_ref_r[ch_r]     <= clamped_ref_s;
                    lo_r[ch_r]        <= nxt_lo_s;
                    hi_r[ch_r]        <= nxt_hi_s;
                    iter_r[ch_r]      <= nxt_iter_s;
                    locked_r[ch_r]    <= nxt_locked_s;
                    need_init_r[ch_r] <= nxt_init_s;
                    state_r           <= ST_NEXT;
                end
                ST_NEXT: begin
                    ch_r <= (ch_r == CH_LAST) ? {CH_IDX_WIDTH{1'b0}} : ch_r + CH_ONE;
                    if (bus.enable) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    meas_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_q_ctrl_multi.sv
// Bench for q_ctrl_multi: acts as the shared measurement path and compares the
// DUT against a transaction-level model of the per-channel search rules.
module tb_q_ctrl_multi;
    localparam int BW = 10, NCH = 4, CIW = 2, TOL = 1, STEP = 4, RELOCK = 50, MAXIT = 12;
    localparam int QMAX = (1 << BW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    q_ctrl_multi_if #(.BUS_WIDTH(BW), .NUM_CH(NCH), .CH_IDX_WIDTH(CIW)) bus();

    q_ctrl_multi #(
        .BUS_WIDTH(BW), .NUM_CH(NCH), .CH_IDX_WIDTH(CIW), .TOL(TOL),
        .STEP(STEP), .RELOCK_THR(RELOCK), .MAX_ITER(MAXIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int m_ref[NCH], m_lo[NCH], m_hi[NCH], m_iter[NCH];
    bit m_locked[NCH], m_need[NCH];
    int m_ptr;
    bit chk_en = 1'b0;

    int cfg_qd[NCH], cfg_max[NCH], cfg_off[NCH], cfg_fix[NCH];
    bit cfg_kind[NCH];

    int start_ref[NCH], upd_ref[NCH];
    bit upd_locked[NCH];
    int hist0[$];
    bit lockhist0[$];
    bit rec0 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < NCH; k++) begin
            bus.q_desired[k*BW +: BW] = BW'(cfg_qd[k]);
            bus.i_ref_max[k*BW +: BW] = BW'(cfg_max[k]);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_ref[k] = 0; m_lo[k] = 0; m_hi[k] = 0; m_iter[k] = 0;
            m_locked[k] = 1'b0; m_need[k] = 1'b1;
        end
        m_ptr = 0;
    endfunction

    function automatic void model_init(input int ch);
        m_lo[ch] = 0; m_hi[ch] = cfg_max[ch]; m_ref[ch] = cfg_max[ch] / 2;
        m_iter[ch] = 0; m_locked[ch] = 1'b0; m_need[ch] = 1'b0;
    endfunction

    function automatic int meas_q(input int ch);
        int v;
        if (cfg_kind[ch]) return cfg_fix[ch];
        v = m_ref[ch] + cfg_off[ch];
        if (v < 0) v = 0;
        if (v > QMAX) v = QMAX;
        return v;
    endfunction

    // The search/tracking rules applied to one measurement, in plain integers.
    function automatic void model_update(input int ch, input int q, input bit trk);
        int err, mag;
        err = cfg_qd[ch] - q;
        mag = (err < 0) ? -err : err;
        if (!m_locked[ch]) begin
            if (mag <= TOL) begin
                m_locked[ch] = 1'b1;
            end else begin
                if (err > 0) m_lo[ch] = m_ref[ch];
                else         m_hi[ch] = m_ref[ch];
                m_ref[ch] = (m_lo[ch] + m_hi[ch]) / 2;
                m_iter[ch]++;
                if (m_hi[ch] - m_lo[ch] <= 1 || m_iter[ch] >= MAXIT) m_locked[ch] = 1'b1;
            end
        end else if (trk) begin
            if (mag > RELOCK) begin
                m_need[ch] = 1'b1;
                m_locked[ch] = 1'b0;
            end else if (mag > TOL) begin
                if (err > 0) m_ref[ch] = (m_ref[ch] + STEP > cfg_max[ch]) ? cfg_max[ch] : m_ref[ch] + STEP;
                else         m_ref[ch] = (m_ref[ch] - STEP < 0) ? 0 : m_ref[ch] - STEP;
            end
        end
        if (m_ref[ch] > cfg_max[ch]) m_ref[ch] = cfg_max[ch];
    endfunction

    // Every-cycle comparison of the per-channel outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NCH*BW-1:0] e_ref;
            logic [NCH-1:0]    e_lk;
            for (int k = 0; k < NCH; k++) begin
                e_ref[k*BW +: BW] = BW'(m_ref[k]);
                e_lk[k] = m_locked[k];
            end
            check("i_ref", bus.i_ref, e_ref);
            check("locked", bus.locked, e_lk);
        end
    end

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (bus.meas_start !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (bus.meas_start === 1'b1);
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL meas_start_timeout: got no meas_start within %0d cycles", n);
        end
    endtask

    task automatic begin_visit(output int ch, output bit ok);
        wait_start(ok);
        ch = m_ptr;
        if (ok) begin
            check("meas_ch", bus.meas_ch, ch);
            check("busy_active", bus.busy, 1);
            if (m_need[ch]) model_init(ch);
            start_ref[ch] = bus.i_ref[ch*BW +: BW];
        end
    endtask

    task automatic do_visit();
        int ch, q, d;
        bit ok, stray;
        begin_visit(ch, ok);
        if (ok) begin
            if (ch == 0 && rec0) hist0.push_back(start_ref[0]);
            d = $urandom_range(1, 4);
            stray = 1'($urandom_range(0, 1));
            if (stray) begin
                bus.ready = 1'b1;
                bus.q_measured = BW'($urandom);
            end
            @(posedge clk); #1;
            bus.ready = 1'b0;
            check("meas_start_pulse", bus.meas_start, 0);
            repeat (d - 1) begin @(posedge clk); #1; end
            q = meas_q(ch);
            bus.ready = 1'b1;
            bus.q_measured = BW'(q);
            @(posedge clk); #1;
            bus.ready = 1'b0;
            bus.q_measured = BW'($urandom);
            @(posedge clk); #1;
            model_update(ch, q, bus.mode);
            upd_ref[ch] = bus.i_ref[ch*BW +: BW];
            upd_locked[ch] = bus.locked[ch];
            if (ch == 0 && rec0) lockhist0.push_back(upd_locked[0]);
            m_ptr = (m_ptr + 1) % NCH;
        end
    endtask

    task automatic visits(input int n);
        repeat (n) do_visit();
    endtask

    int exp_bis[8] = '{511, 255, 383, 319, 287, 303, 295, 299};
    int exp_trk[4] = '{303, 307, 311, 311};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ch;
        bit ok;
        rst = 1'b1;
        bus.enable = 1'b0; bus.mode = 1'b0; bus.ready = 1'b0; bus.q_measured = '0;
        cfg_qd  = '{300, 1001, 500, 350};
        cfg_max = '{1023, 1023, 0, 700};
        cfg_off = '{0, 0, 0, 5};
        cfg_fix = '{0, 0, 0, 0};
        cfg_kind = '{0, 0, 0, 0};
        apply_cfg();
        model_reset();
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_i_ref", bus.i_ref, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_meas_start", bus.meas_start, 0);
        check("rst_meas_ch", bus.meas_ch, 0);
        check("rst_busy", bus.busy, 0);

        // Bisection, round-robin order and the zero-bound channel.
        bus.enable = 1'b1;
        rec0 = 1'b1;
        visits(4);
        check("zero_max_ref", upd_ref[2], 0);
        check("zero_max_locked", upd_locked[2], 1);
        visits(44);
        rec0 = 1'b0;
        for (int i = 0; i < 8; i++)
            check("bisect_seq", (i < hist0.size()) ? hist0[i] : -1, exp_bis[i]);
        check("locked_after_7", (lockhist0.size() > 6) ? lockhist0[6] : 1'b1, 0);
        check("locked_after_8", (lockhist0.size() > 7) ? lockhist0[7] : 1'b0, 1);
        check("ch1_locked", bus.locked[1], 1);

        // Tracking steps on channel 0.
        bus.mode = 1'b1;
        cfg_off[0] = -10;
        for (int r = 0; r < 4; r++) begin
            visits(4);
            check("track_step", upd_ref[0], exp_trk[r]);
        end

        // Upward tracking saturation on channel 1.
        cfg_kind[1] = 1'b1;
        cfg_fix[1] = 981;
        visits(20);
        check("sat_pre", upd_ref[1], 1021);
        visits(4);
        check("sat_hit", upd_ref[1], 1023);
        visits(8);
        check("sat_hold", upd_ref[1], 1023);

        // Large error forces a restart from mid-range.
        cfg_qd[0] = 900;
        apply_cfg();
        visits(4);
        check("relock_unlocked", upd_locked[0], 0);
        visits(4);
        check("relock_restart", start_ref[0], 511);

        // Enable dropped mid-measurement: same channel resumes.
        begin_visit(ch, ok);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        check("drop_busy", bus.busy, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("drop_no_start", bus.meas_start, 0);
        end
        bus.enable = 1'b1;
        visits(8);

        // Randomized configurations and modes.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, NCH - 1);
                cfg_qd[ch] = $urandom_range(0, QMAX);
                cfg_max[ch] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, QMAX);
                cfg_off[ch] = $urandom_range(0, 1) ? ($urandom_range(0, 60) - 30) : ($urandom_range(0, 400) - 200);
                cfg_kind[ch] = ($urandom_range(0, 3) == 0);
                cfg_fix[ch] = $urandom_range(0, QMAX);
                apply_cfg();
            end
            bus.mode = 1'($urandom_range(0, 1));
            do_visit();
        end

        // Reset while waiting for a measurement, then a late ready.
        begin_visit(ch, ok);
        @(posedge clk); #1;
        bus.enable = 1'b0;
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        bus.ready = 1'b1;
        bus.q_measured = BW'(77);
        @(posedge clk); #1;
        bus.ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rstw_i_ref", bus.i_ref, 0);
        check("rstw_locked", bus.locked, 0);
        check("rstw_meas_start", bus.meas_start, 0);
        check("rstw_meas_ch", bus.meas_ch, 0);
        check("rstw_busy", bus.busy, 0);
        bus.enable = 1'b1;
        visits(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
